// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port RAM whose
// read data is registered (one cycle latency). Each accepted transaction
// walks IDLE -> ISSUE (-> WAIT for reads) -> IDLE.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN. When it is defined,
// contention goes to the requester not granted last. When it is undefined,
// requester 0 always wins contention.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic                    we_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic                    owner_reg;   // 0 = requester 0, 1 = requester 1
    logic                    accept;
    logic                    winner;

    // Inputs are only looked at while idle; any pending request starts a transaction.
    assign accept = (state_reg == IDLE) && (req0 || req1);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_winner_reg;

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        winner = (req0 && req1) ? ~last_winner_reg : ~req0;
    end

    // Remember the winner of every grant; reset value makes requester 0 win first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_winner_reg <= 1'b1;
        end else if (accept) begin
            last_winner_reg <= winner;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        winner = ~req0;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: writes take two cycles, reads wait one more for RAM data.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = (req0 || req1) ? ISSUE : IDLE;
            ISSUE:   state_next = we_reg ? IDLE : WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state: RAM is only written during ISSUE, address held otherwise.
    always_comb begin
        busy      = (state_reg != IDLE);
        ram_we    = (state_reg == ISSUE) && we_reg;
        ram_addr  = addr_reg;
        ram_wdata = wdata_reg;
    end

    // Latch the winning request and emit the one-cycle grant pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            owner_reg <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
        end else begin
            gnt0 <= accept && !winner;
            gnt1 <= accept && winner;
            if (accept) begin
                owner_reg <= winner;
                we_reg    <= winner ? we1 : we0;
                addr_reg  <= winner ? addr1 : addr0;
                wdata_reg <= winner ? wdata1 : wdata0;
            end
        end
    end

    // Capture RAM read data for the owner when leaving WAIT; pulse its rvalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= (state_reg == WAIT) && !owner_reg;
            rvalid1 <= (state_reg == WAIT) && owner_reg;
            if (state_reg == WAIT) begin
                if (owner_reg) begin
                    rdata1 <= ram_rdata;
                end else begin
                    rdata0 <= ram_rdata;
                end
            end
        end
    end

endmodule
